// File: rtl/pipe_stage_fifo_pkg.sv
// Shared pipeline datapath types: stage bundles, hazard-unit control, and
// the pointer/occupancy width helpers used by the elastic stage buffer.
package pipe_stage_fifo_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } fetch_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  uop;
  } decode_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        mem_rd;
    logic        mem_wr;
  } execute_data_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        wb_en;
  } memory_data_t;

  // Driven as one field by the hazard unit so stall and flush move together.
  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

  // A single-entry buffer has no pointers; use a constant 1-bit pointer
  // width so port widths never collapse to zero.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_fifo_ptr.sv
// Read/write pointer and occupancy tracking for the stage buffer.
// Flush has priority; pointers wrap naturally because DEPTH is a power of two.
module fifo_ptr
  import pipe_stage_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = ptr_width(DEPTH),
  parameter int unsigned CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [PTR_W-1:0] rp_o,
  output logic [PTR_W-1:0] wp_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  generate
    if (DEPTH > 1) begin : g_ptr
      logic [PTR_W-1:0] rp_q, rp_d, wp_q, wp_d;

      always_comb begin
        rp_d = rp_q;
        wp_d = wp_q;
        if (flush_i) begin
          rp_d = '0;
          wp_d = '0;
        end else begin
          if (pop_i)  rp_d = rp_q + PTR_W'(1);
          if (push_i) wp_d = wp_q + PTR_W'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rp_q <= '0;
          wp_q <= '0;
        end else begin
          rp_q <= rp_d;
          wp_q <= wp_d;
        end
      end

      assign rp_o = rp_q;
      assign wp_o = wp_q;
    end else begin : g_noptr
      assign rp_o = '0;
      assign wp_o = '0;
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with hazard stall/flush and
// a saturating back-pressure counter for performance monitoring.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CW    = count_width(DEPTH);

  // Handshake: a transfer happens on a side when its valid and ready are both
  // high at the rising edge. in_ready and out_valid depend only on stall and
  // registered state, never on the partner's valid/ready.
  logic [PTR_W-1:0]  rp, wp;
  logic [CW-1:0]     occ;
  logic              full, empty;
  logic              push, pop, stall_inc;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_ready  = !stall && !full;
  assign out_valid = !stall && !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign stall_inc = in_valid && !in_ready && !flush;

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CW    (CW)
  ) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .rp_o    (rp),
    .wp_o    (wp),
    .count_o (occ),
    .full_o  (full),
    .empty_o (empty)
  );

  // Storage is left uncleared on reset and flush; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp] <= in_data;
    end
  end

  assign out_data = mem_q[rp];
  assign count    = occ;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: three instances (DEPTH 4, 2, 1) share one input
// stream and are each compared against a queue-based reference model.
module tb_pipe_stage_fifo;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, out_ready, stall, flush;
  logic [W-1:0] in_data;

  logic         ir [3];
  logic         ov [3];
  logic [W-1:0] od [3];
  logic [2:0]   cnt0;
  logic [1:0]   cnt1;
  logic [0:0]   cnt2;
  logic [31:0]  sc0, sc1;
  logic [3:0]   sc2;
  logic [31:0]  obs_cnt [3];
  logic [31:0]  obs_sc  [3];

  assign obs_cnt[0] = 32'(cnt0);
  assign obs_cnt[1] = 32'(cnt1);
  assign obs_cnt[2] = 32'(cnt2);
  assign obs_sc[0]  = sc0;
  assign obs_sc[1]  = sc1;
  assign obs_sc[2]  = 32'(sc2);

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DATA_W(W), .DEPTH(4), .CNT_W(32)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .stall(stall), .flush(flush), .count(cnt0), .stall_cycles(sc0));

  pipe_stage_fifo #(.DATA_W(W), .DEPTH(2), .CNT_W(32)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .stall(stall), .flush(flush), .count(cnt1), .stall_cycles(sc1));

  pipe_stage_fifo #(.DATA_W(W), .DEPTH(1), .CNT_W(4)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready),
    .stall(stall), .flush(flush), .count(cnt2), .stall_cycles(sc2));

  // Reference model: FIFO contents as a queue, plus the saturating counter.
  int           depth [3] = '{4, 2, 1};
  logic [31:0]  sc_max [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15};
  logic [W-1:0] exp_q [3][$];
  logic [31:0]  m_sc [3];
  logic         acc0;
  int           pops0;
  int           n_checks = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic m_ir(input int k);
    return !stall && (exp_q[k].size() < depth[k]);
  endfunction

  function automatic logic m_ov(input int k);
    return !stall && (exp_q[k].size() > 0);
  endfunction

  task automatic model_clear(input logic clr_sc);
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      if (clr_sc) m_sc[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("in_ready", k, 32'(ir[k]), 32'(m_ir(k)));
      chk("out_valid", k, 32'(ov[k]), 32'(m_ov(k)));
      chk("count", k, obs_cnt[k], 32'(exp_q[k].size()));
      chk("stall_cycles", k, obs_sc[k], m_sc[k]);
      if (m_ov(k)) chk("out_data", k, 32'(od[k]), 32'(exp_q[k][0]));
    end
  endtask

  task automatic step_model();
    acc0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic rdy, vld;
      rdy = m_ir(k);
      vld = m_ov(k);
      if (in_valid && !rdy && !flush && m_sc[k] != sc_max[k]) m_sc[k]++;
      if (flush) begin
        exp_q[k].delete();
      end else begin
        if (vld && out_ready) begin
          void'(exp_q[k].pop_front());
          if (k == 0) pops0++;
        end
        if (in_valid && rdy) begin
          exp_q[k].push_back(in_data);
          if (k == 0) acc0 = 1'b1;
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1;
    check_all();
    step_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear(1'b1);
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    idle_inputs();
    reset = 1'b1;
    model_clear(1'b1);
    pops0 = 0;
    @(negedge clk);
    do_reset();

    // Fill the DEPTH=2 instance with 0x1, 0x2 and hold a third push.
    in_valid = 1'b1; out_ready = 1'b0;
    in_data = 16'h1; cycle();
    in_data = 16'h2; cycle();
    in_data = 16'h3; cycle();
    #1;
    chk("fill_count", 1, 32'(cnt1), 32'd2);
    chk("fill_in_ready", 1, 32'(ir[1]), 32'd0);
    chk("fill_out_data", 1, 32'(od[1]), 32'h1);
    chk("fill_stall_cycles", 1, sc1, 32'd1);

    // Flush with simultaneous push and pop while DEPTH=4 holds three entries.
    chk("pre_flush_count", 0, 32'(cnt0), 32'd3);
    in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b1; flush = 1'b1;
    cycle();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("post_flush_count", 0, 32'(cnt0), 32'd0);
    chk("post_flush_out_valid", 0, 32'(ov[0]), 32'd0);
    repeat (3) cycle();

    // Stall freeze with one entry and both sides requesting.
    do_reset();
    in_valid = 1'b1; in_data = 16'h0011; out_ready = 1'b0;
    cycle();
    stall = 1'b1; out_ready = 1'b1; in_data = 16'h0022;
    repeat (5) cycle();
    #1;
    chk("stall_count", 0, 32'(cnt0), 32'd1);
    chk("stall_cycles_5", 0, sc0, 32'd5);
    stall = 1'b0; in_valid = 1'b0;
    repeat (3) cycle();

    // Streaming 0..99 with the consumer always ready.
    do_reset();
    pops0 = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data = W'(i);
      guard = 0;
      do begin
        cycle();
        guard++;
      end while (!acc0 && guard < 20);
      chk("stream_accept", 0, 32'(acc0), 32'd1);
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    chk("stream_pops", 0, 32'(pops0), 32'd100);
    chk("stream_stall_cycles", 0, sc0, 32'd0);

    // Asynchronous reset between edges with two entries buffered.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    in_data = 16'h0101; cycle();
    in_data = 16'h0202; cycle();
    in_valid = 1'b0;
    #1;
    chk("pre_reset_count", 0, 32'(cnt0), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", 0, 32'(cnt0), 32'd0);
    chk("async_out_valid", 0, 32'(ov[0]), 32'd0);
    model_clear(1'b1);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("after_reset_first", 0, 32'(od[0]), 32'h0055);
    repeat (3) cycle();

    // Sustained back-pressure saturates the 4-bit counter of DEPTH=1.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = W'(16'h0300 + i);
      cycle();
    end
    #1;
    chk("sat_stall_cycles", 2, 32'(sc2), 32'd15);
    chk("bp_stall_cycles", 0, sc0, 32'd16);

    // DEPTH=1 under continuous traffic alternates push and pop.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = W'(16'h0400 + i);
      cycle();
    end

    // Randomized traffic including stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom_range(0, 65535));
      out_ready = ($urandom_range(0, 1) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised successor to the fixed stall/flush pipeline registers between pipeline stages (F/D/E/M/W).

- Carries one stage's data bundle (`fetch_data_t`, `decode_data_t`, …, flattened to `DATA_W` bits) through a `DEPTH`-entry elastic buffer.
- Uses a valid/ready handshake, plus the hazard unit's `stall` and `flush` controls.
- Decouples the producer stage from the consumer stage, so a multi-cycle consumer (cache miss, divider) does not immediately stall the producer.
- One instance sits between each pair of adjacent stages. Occupancy and stall-cycle counts are exported for performance counters.

## Interface
Parameters:
- `DATA_W`, 128: width of the flattened stage bundle.
- `DEPTH`, 2: number of buffer entries; power of two, minimum 1.
- `CNT_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer presents `in_data`.
- `in_data`  in  `DATA_W`  producer bundle.
- `in_ready`  out  1  buffer can accept this cycle.
- `out_valid`  out  1  head entry is valid.
- `out_data`  out  `DATA_W`  head entry.
- `out_ready`  in  1  consumer takes the head this cycle.
- `stall`  in  1  hazard-unit freeze: no push, no pop.
- `flush`  in  1  hazard-unit squash of all contents.
- `count`  out  $clog2(`DEPTH`+1)  current occupancy.
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `in_valid & !in_ready`.

## Operation
- **Storage:** circular array of `DEPTH` entries, with read pointer `rp`, write pointer `wp` and occupancy `count`. Pointers are $clog2(`DEPTH`) bits and wrap modulo `DEPTH`. For `DEPTH`=1 the pointers are absent.
- **Handshake signals:**
  - `in_ready = !stall & (count != DEPTH)`.
  - `out_valid = !stall & (count != 0)`.
  - `out_data` is the entry at `rp`. Its value is don't-care when `out_valid`=0.
- **Push/pop conditions:**
  - push = `in_valid & in_ready & !flush`.
  - pop = `out_valid & out_ready & !flush`.
  - A push when full is impossible, because `in_ready` is 0.
- **Simultaneous push and pop** (`count` between 1 and `DEPTH`-1, or `count`=`DEPTH` is impossible since `in_ready` is 0): both pointers advance and `count` is unchanged.
- **Push and pop with `count`=0:** not allowed. `out_valid` is 0, so the pushed entry appears only next cycle (no bypass).
- **Flush:**
  - Takes priority over everything else.
  - Next cycle: `count`=0 and `rp`=`wp`=0.
  - The cycle's push is discarded. Entry contents are not cleared.
- **Stall:** holds all state. `in_ready` and `out_valid` are forced to 0.
- **Flush and stall in the same cycle:** flush wins.
- **`stall_cycles`:** increments when `in_valid & !in_ready & !flush`, including stall-induced back-pressure. It saturates at all-ones and is cleared only by reset.

## Timing
- Reset values: `count`=0, `rp`=`wp`=0, `stall_cycles`=0, `out_valid`=0, `in_ready`=1 (when `stall`=0). `out_data` is don't-care.
- Latency: an entry pushed in cycle t is presented at `out_valid` in cycle t+1 at the earliest.
- Throughput: one transfer per cycle sustained when `DEPTH`≥2 and `out_ready`=1. `DEPTH`=1 alternates push and pop, giving half rate (the accepted trade-off).
- Combinational paths:
  - `in_ready` does not depend on `out_ready`.
  - `out_valid` does not depend on `in_valid`.
  - The only combinational inputs to the handshake outputs are `stall` and registered state.
- Reset asserted mid-operation clears state immediately and asynchronously. Outputs follow from the reset state in the same cycle.
- Deassertion of `reset` is synchronised externally; the block needs no internal synchroniser.

## Structure
- The shared datapath package holds the stage bundle typedefs. The instantiating stage packs its bundle with `$bits(...)` into `DATA_W`; the block is type-agnostic.
- The package also holds a `pipe_ctrl_t` struct {stall, flush} so that `hazard_intf` modports can drive both signals as one field.
- One sub-module is natural: `fifo_ptr`. It holds the wrapping pointer increment and the occupancy update, is parametrised on `DEPTH`, and is instantiated once.
- The storage array is a plain flop array; no RAM macro.

## Test plan
- **Reset/fill, `DEPTH`=2:** reset; push A=0x1, B=0x2 with `out_ready`=0 → `count`=2, `in_ready`=0, `out_data`=0x1; third `in_valid` held → `stall_cycles` increments to 1.
- **Streaming, `DEPTH`=4:** 100 consecutive pushes of 0..99 with `out_ready`=1 → outputs 0..99 in order, one per cycle after the first-cycle latency, pointers wrap 25 times, `stall_cycles`=0.
- **Flush with simultaneous push:** `count`=3, push 0xAA and pop together with `flush`=1 → next cycle `count`=0, `out_valid`=0; 0xAA is never emitted.
- **Stall freeze:** `count`=1, `stall`=1 for 5 cycles with `in_valid`=`out_ready`=1 → `count` stays 1, no transfer, `stall_cycles`=5.
- **Async reset mid-stream:** assert `reset` between clock edges with `count`=2 → `count`=0 and `out_valid`=0 before the next edge; a push after release is emitted first.
- **`DEPTH`=1 corner and saturation:** continuous traffic → transfers on alternate cycles only; with `CNT_W`=4, 20 back-pressured cycles → `stall_cycles`=15.
